// File: rtl/shift_issue_stage.sv
// shift_issue_stage
// Issue stage in front of the 32-bit shift unit. Decodes shift ops into
// operand, zero-extended shift amount and direction/arithmetic controls,
// and buffers them in a two-entry skid buffer (main + skid) so the stage
// keeps one op per cycle while the shifter applies back-pressure.
// Optional build macro SHIFT_ISSUE_STAT_EN adds the stat_count (ops
// transferred out) and stat_stall (stalled output cycles) counters.
module shift_issue_stage #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5,
   parameter int RD_W    = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         in_op,
   input  logic [DATA_W-1:0]  in_rs,
   input  logic [DATA_W-1:0]  in_rt,
   input  logic [SHAMT_W-1:0] in_shimm,
   input  logic [RD_W-1:0]    in_rd,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_a,
   output logic [DATA_W-1:0]  out_shamt,
   output logic               out_right,
   output logic               out_arith,
   output logic [RD_W-1:0]    out_rd,
   output logic               err_illegal
`ifdef SHIFT_ISSUE_STAT_EN
   ,
   output logic [31:0]        stat_count,
   output logic [31:0]        stat_stall
`endif
);

   localparam logic [2:0] OP_SLL  = 3'b000;
   localparam logic [2:0] OP_SRL  = 3'b001;
   localparam logic [2:0] OP_SRA  = 3'b010;
   localparam logic [2:0] OP_SLLV = 3'b011;
   localparam logic [2:0] OP_SRLV = 3'b100;
   localparam logic [2:0] OP_SRAV = 3'b101;

   typedef struct packed {
      logic [DATA_W-1:0]  a;
      logic [SHAMT_W-1:0] shamt;
      logic               right;
      logic               arith;
      logic [RD_W-1:0]    rd;
   } entry_t;

   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   entry_t new_entry;
   logic   main_valid_q, main_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   err_q, err_d;
   logic   new_legal;
   logic   new_variable;
   logic   accept;
   logic   load;
   logic   drain;

   // Only the low SHAMT_W bits of rt matter; the rest are deliberately dropped.
   logic unused_rt_bits;
   assign unused_rt_bits = ^in_rt[DATA_W-1:SHAMT_W];

   // Decode the offered op into the entry it would become if accepted.
   always_comb begin
      new_variable    = (in_op == OP_SLLV) || (in_op == OP_SRLV) || (in_op == OP_SRAV);
      new_legal       = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA) || new_variable;
      new_entry.a     = in_rs;
      new_entry.shamt = new_variable ? in_rt[SHAMT_W-1:0] : in_shimm;
      new_entry.right = (in_op == OP_SRL) || (in_op == OP_SRA) ||
                        (in_op == OP_SRLV) || (in_op == OP_SRAV);
      new_entry.arith = (in_op == OP_SRA) || (in_op == OP_SRAV);
      new_entry.rd    = in_rd;
   end

   // Ready depends only on skid occupancy, never on out_ready, which breaks the combinational path.
   assign in_ready = ~skid_valid_q;
   assign accept   = in_valid && in_ready && !flush;
   assign load     = accept && new_legal;
   assign drain    = main_valid_q && out_ready;

   // Skid buffer next-state: flush wins, otherwise refill main from skid or the new op, spilling to skid when main is stuck.
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      err_d        = 1'b0;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         err_d = accept && !new_legal;
         if (drain) begin
            if (skid_valid_q) begin
               main_d       = skid_q;
               main_valid_d = 1'b1;
               skid_valid_d = 1'b0;
            end else if (load) begin
               main_d       = new_entry;
               main_valid_d = 1'b1;
            end else begin
               main_valid_d = 1'b0;
            end
         end else if (!main_valid_q) begin
            if (load) begin
               main_d       = new_entry;
               main_valid_d = 1'b1;
            end
         end else if (load) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
         end
      end
   end

   // State registers; reset empties both entries and clears all payload.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         err_q        <= err_d;
      end
   end

   assign out_valid   = main_valid_q;
   assign out_a       = main_q.a;
   assign out_shamt   = {{(DATA_W-SHAMT_W){1'b0}}, main_q.shamt};
   assign out_right   = main_q.right;
   assign out_arith   = main_q.arith;
   assign out_rd      = main_q.rd;
   assign err_illegal = err_q;

`ifdef SHIFT_ISSUE_STAT_EN
   logic [31:0] stat_count_q, stat_count_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   // Counters wrap naturally and are deliberately left untouched by flush.
   always_comb begin
      stat_count_d = stat_count_q;
      stat_stall_d = stat_stall_q;
      if (main_valid_q && out_ready)
         stat_count_d = stat_count_q + 32'd1;
      if (main_valid_q && !out_ready)
         stat_stall_d = stat_stall_q + 32'd1;
   end

   // Statistic registers, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_count_q <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_count_q <= stat_count_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_count = stat_count_q;
   assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed testbench for shift_issue_stage. Inputs change and outputs are
// sampled 1ns after each rising edge; expected values are hand-computed.
module tb_shift_issue_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        inValid;
   logic        inReady;
   logic [2:0]  inOp;
   logic [31:0] inRs;
   logic [31:0] inRt;
   logic [4:0]  inShimm;
   logic [4:0]  inRd;
   logic        outValid;
   logic        outReady;
   logic [31:0] outA;
   logic [31:0] outShamt;
   logic        outRight;
   logic        outArith;
   logic [4:0]  outRd;
   logic        errIllegal;
`ifdef SHIFT_ISSUE_STAT_EN
   logic [31:0] statCount;
   logic [31:0] statStall;
`endif

   int testsRun;
   int testsFailed;

   shift_issue_stage dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .in_op      (inOp),
      .in_rs      (inRs),
      .in_rt      (inRt),
      .in_shimm   (inShimm),
      .in_rd      (inRd),
      .out_valid  (outValid),
      .out_ready  (outReady),
      .out_a      (outA),
      .out_shamt  (outShamt),
      .out_right  (outRight),
      .out_arith  (outArith),
      .out_rd     (outRd),
      .err_illegal(errIllegal)
`ifdef SHIFT_ISSUE_STAT_EN
      ,
      .stat_count (statCount),
      .stat_stall (statStall)
`endif
   );

   // Free-running 10ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [4:0] shimm, input logic [4:0] rd);
      inValid = valid;
      inOp    = op;
      inRs    = rs;
      inRt    = rt;
      inShimm = shimm;
      inRd    = rd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] shifterResult;

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst         = 1'b0;
      flush       = 1'b0;
      outReady    = 1'b1;
      applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0);

      // Reset state
      #3;
      checkOutput("reset out_valid", {31'b0, outValid}, 32'h0);
      checkOutput("reset err", {31'b0, errIllegal}, 32'h0);
      checkOutput("reset out_a", outA, 32'h0);
      #9 rst = 1'b1;
      tick();
      checkOutput("in_ready after reset", {31'b0, inReady}, 32'h1);

      // SRA imm: 0x80000010 >>> 4
      applyStimulus(1'b1, 3'b010, 32'h8000_0010, 32'h0, 5'd4, 5'd3);
      tick();
      applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0);
      checkOutput("sra out_valid", {31'b0, outValid}, 32'h1);
      checkOutput("sra out_a", outA, 32'h8000_0010);
      checkOutput("sra out_shamt", outShamt, 32'h0000_0004);
      checkOutput("sra out_right", {31'b0, outRight}, 32'h1);
      checkOutput("sra out_arith", {31'b0, outArith}, 32'h1);
      checkOutput("sra out_rd", {27'b0, outRd}, 32'd3);
      if (outRight && outArith)
         shifterResult = $unsigned($signed(outA) >>> outShamt[4:0]);
      else if (outRight)
         shifterResult = outA >> outShamt[4:0];
      else
         shifterResult = outA << outShamt[4:0];
      checkOutput("sra shifter result", shifterResult, 32'hF800_0001);

      // SLLV uses only low 5 bits of rt
      applyStimulus(1'b1, 3'b011, 32'h0000_0001, 32'hFFFF_FF25, 5'd7, 5'd9);
      tick();
      applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0);
      checkOutput("sllv out_shamt", outShamt, 32'h0000_0005);
      checkOutput("sllv out_right", {31'b0, outRight}, 32'h0);
      checkOutput("sllv out_arith", {31'b0, outArith}, 32'h0);
      checkOutput("sllv out_rd", {27'b0, outRd}, 32'd9);
      tick();
      checkOutput("sllv drained", {31'b0, outValid}, 32'h0);

      // Back-pressure: A in main, B in skid, C stalled
      outReady = 1'b0;
      applyStimulus(1'b1, 3'b001, 32'h0000_000A, 32'h0, 5'd1, 5'd1);
      tick();
      checkOutput("bp A in main", outA, 32'h0000_000A);
      checkOutput("bp ready after A", {31'b0, inReady}, 32'h1);
      applyStimulus(1'b1, 3'b001, 32'h0000_000B, 32'h0, 5'd2, 5'd2);
      tick();
      checkOutput("bp ready after B", {31'b0, inReady}, 32'h0);
      checkOutput("bp A held", outA, 32'h0000_000A);
      applyStimulus(1'b1, 3'b100, 32'h0000_000C, 32'h0000_0023, 5'd0, 5'd4);
      tick();
      checkOutput("bp C stalled ready", {31'b0, inReady}, 32'h0);
      checkOutput("bp A still held", outA, 32'h0000_000A);
      checkOutput("bp A shamt held", outShamt, 32'h0000_0001);
      outReady = 1'b1;
      tick();
      checkOutput("bp B out valid", {31'b0, outValid}, 32'h1);
      checkOutput("bp B out a", outA, 32'h0000_000B);
      checkOutput("bp ready back", {31'b0, inReady}, 32'h1);
      tick();
      applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0);
      checkOutput("bp C out valid", {31'b0, outValid}, 32'h1);
      checkOutput("bp C out a", outA, 32'h0000_000C);
      checkOutput("bp C shamt", outShamt, 32'h0000_0003);
      checkOutput("bp C right", {31'b0, outRight}, 32'h1);
      tick();
      checkOutput("bp drained", {31'b0, outValid}, 32'h0);

      // Illegal op pulses err for one cycle and is not forwarded
      applyStimulus(1'b1, 3'b111, 32'h1234_5678, 32'h0, 5'd1, 5'd5);
      tick();
      applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0);
      checkOutput("illegal err pulse", {31'b0, errIllegal}, 32'h1);
      checkOutput("illegal not forwarded", {31'b0, outValid}, 32'h0);
      applyStimulus(1'b1, 3'b100, 32'hF000_0000, 32'h0000_0021, 5'd0, 5'd6);
      tick();
      applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0);
      checkOutput("illegal err cleared", {31'b0, errIllegal}, 32'h0);
      checkOutput("post-illegal valid", {31'b0, outValid}, 32'h1);
      checkOutput("post-illegal shamt", outShamt, 32'h0000_0001);
      checkOutput("post-illegal arith", {31'b0, outArith}, 32'h0);
      tick();

      // Flush with both entries full and a new op offered
      outReady = 1'b0;
      applyStimulus(1'b1, 3'b000, 32'h0000_0D01, 32'h0, 5'd1, 5'd1);
      tick();
      applyStimulus(1'b1, 3'b000, 32'h0000_0D02, 32'h0, 5'd2, 5'd2);
      tick();
      checkOutput("flush pre skid full", {31'b0, inReady}, 32'h0);
      applyStimulus(1'b1, 3'b000, 32'h0000_0D03, 32'h0, 5'd3, 5'd3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0);
      checkOutput("flush out_valid", {31'b0, outValid}, 32'h0);
      checkOutput("flush in_ready", {31'b0, inReady}, 32'h1);
      checkOutput("flush err", {31'b0, errIllegal}, 32'h0);
      outReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("flush no resurrect", {31'b0, outValid}, 32'h0);
      end
      // Flush also drops an accepted-looking illegal op and its error
      applyStimulus(1'b1, 3'b110, 32'h0, 32'h0, 5'd0, 5'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0);
      checkOutput("flush suppresses err", {31'b0, errIllegal}, 32'h0);

`ifdef SHIFT_ISSUE_STAT_EN
      checkOutput("stat_count before reset", statCount, 32'd6);
`endif

      // Asynchronous reset mid-stall, off the clock edge
      outReady = 1'b0;
      applyStimulus(1'b1, 3'b010, 32'hAAAA_5555, 32'h0, 5'd7, 5'd7);
      tick();
      applyStimulus(1'b1, 3'b101, 32'h5555_AAAA, 32'h0000_0009, 5'd0, 5'd8);
      tick();
      applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0);
      checkOutput("stall before reset", {31'b0, outValid}, 32'h1);
      #2 rst = 1'b0;
      #1;
      checkOutput("async rst out_valid", {31'b0, outValid}, 32'h0);
      checkOutput("async rst out_a", outA, 32'h0);
      checkOutput("async rst out_shamt", outShamt, 32'h0);
      checkOutput("async rst out_rd", {27'b0, outRd}, 32'h0);
      checkOutput("async rst in_ready", {31'b0, inReady}, 32'h1);
`ifdef SHIFT_ISSUE_STAT_EN
      checkOutput("async rst stat_count", statCount, 32'd0);
      checkOutput("async rst stat_stall", statStall, 32'd0);
`endif
      tick();
      rst = 1'b1;
      outReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 3'b000, 32'h0000_0100 + i, 32'h0, 5'(i), 5'(i));
         tick();
         checkOutput("post-reset op a", outA, 32'h0000_0100 + i);
      end
      applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0);
      tick();
      checkOutput("post-reset drained", {31'b0, outValid}, 32'h0);
`ifdef SHIFT_ISSUE_STAT_EN
      checkOutput("stat_count after 3", statCount, 32'd3);
      checkOutput("stat_stall after 3", statStall, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Pipeline stage directly upstream of the 32-bit shift unit in the KGP_RISC execute path.
- Accepts decoded shift instructions with register operands and resolves the direction, the arithmetic/logical mode and the shift amount.
- Registers the result and presents operand A, a 32-bit zero-extended shift amount and control bits to the shifter.
- Uses a two-entry skid buffer with valid/ready handshakes on both sides, so the stage sustains one op per cycle under back-pressure.

Parameters:
- DATA_W, 32, operand and shift-amount width.
- SHAMT_W, 5, number of significant shift-amount bits (log2 DATA_W).
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  upstream op valid.
- in_ready  output  1  stage can accept an op this cycle.
- in_op  input  3  op code: 000 SLL imm, 001 SRL imm, 010 SRA imm, 011 SLLV, 100 SRLV, 101 SRAV, 110/111 illegal.
- in_rs  input  DATA_W  value to be shifted.
- in_rt  input  DATA_W  variable shift source; only low SHAMT_W bits are used.
- in_shimm  input  SHAMT_W  immediate shift amount.
- in_rd  input  RD_W  destination register tag, passed through.
- out_valid  output  1  op presented to shifter.
- out_ready  input  1  shifter/downstream accepts op.
- out_a  output  DATA_W  operand to shift.
- out_shamt  output  DATA_W  shift amount, bits [DATA_W-1:SHAMT_W] always 0.
- out_right  output  1  1 = right shift, 0 = left shift.
- out_arith  output  1  1 = arithmetic (sign fill); valid only with out_right=1.
- out_rd  output  RD_W  destination tag.
- err_illegal  output  1  one-cycle pulse when an illegal op is accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - main and skid entries become invalid; all payload registers clear to 0.
  - out_valid=0, err_illegal=0.
  - in_ready=1 from the first cycle after reset release.
- Handshakes:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - in_ready is a registered signal equal to NOT skid_valid; it does not depend combinationally on out_ready.
- Decode (applied at acceptance):
  - Immediate ops: shamt = in_shimm.
  - Variable ops: shamt = in_rt[SHAMT_W-1:0], so shifts are effectively modulo 32.
  - out_right = op in {SRL, SRA, SRLV, SRAV}.
  - out_arith = op in {SRA, SRAV}.
  - out_a = in_rs.
- Latency: 1 cycle from input acceptance to out_valid; throughput 1 op per cycle.
- Buffer rules:
  - Accept with main empty, or with main draining this cycle and skid empty: the op loads into main.
  - Accept while main is full and not draining: the op loads into skid, and in_ready drops next cycle.
  - Main drains while skid is valid: skid moves into main and skid clears, so in_ready returns next cycle.
  - Main drains with no new op and skid empty: main becomes invalid.
  - Ordering is strictly FIFO; no op is lost or duplicated.
- Illegal ops (110/111):
  - Accepted normally (in_ready is honoured), not forwarded, no buffer entry consumed.
  - err_illegal pulses high in the cycle after acceptance.
- Flush: synchronous, has priority over all other events.
  - Invalidates main and skid.
  - Any op offered in the same cycle is dropped, and err_illegal is suppressed.
  - Next cycle: out_valid=0, in_ready=1.
- Reset asserted mid-operation discards all held ops immediately.
- Outputs must hold stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro SHIFT_ISSUE_STAT_EN.
- Defined:
  - Adds output stat_count (32 bits), counting ops transferred out (out_valid and out_ready).
  - Counter clears on reset, wraps from 0xFFFFFFFF to 0, and is not cleared by flush.
  - Adds output stat_stall (32 bits), counting cycles with out_valid=1 and out_ready=0; same clear and wrap rules.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset release, then SRA imm with rs=0x80000010, shimm=4, out_ready=1 -> next cycle out_valid=1, out_a=0x80000010, out_shamt=0x00000004, out_right=1, out_arith=1, and the downstream shifter yields 0xF8000001.
- SLLV with rt=0xFFFFFF25 -> out_shamt=0x00000005, out_right=0, out_arith=0.
- Back-pressure: out_ready=0, three back-to-back ops A, B, C offered -> A held in main, B in skid, in_ready=0 and C stalled. Raise out_ready -> A, B, C emerge in order on consecutive cycles with no gaps.
- Illegal op 111 with in_valid=1 -> err_illegal=1 for exactly one cycle, out_valid stays 0, and the following legal op passes normally.
- Flush with main and skid both full and a new op offered -> next cycle out_valid=0, in_ready=1, err_illegal=0, and no held op ever appears on the output.
- Asynchronous reset asserted mid-stall, off a clock edge -> out_valid=0 and payload=0 immediately. With SHIFT_ISSUE_STAT_EN defined, stat_count=0; after 3 completed transfers, stat_count=3.
